// File: rtl/vfr_frame_fetch_ctrl_if.sv
// Bus bundle for the frame-fetch engine: Avalon-MM bursting read master
// plus the word stream into the pixel FIFO with its pop-credit return.
interface vfr_frame_fetch_ctrl_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 64,
   parameter int BURST_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0]  mst_address;
   logic                   mst_read;
   logic [BURST_WIDTH-1:0] mst_burstcount;
   logic                   mst_waitrequest;
   logic [DATA_WIDTH-1:0]  mst_readdata;
   logic                   mst_readdatavalid;
   logic [DATA_WIDTH-1:0]  dout_data;
   logic                   dout_valid;
   logic                   dout_sop;
   logic                   dout_eop;
   logic                   dout_pop;

   modport master (
      output mst_address, mst_read, mst_burstcount,
      input  mst_waitrequest, mst_readdata, mst_readdatavalid,
      output dout_data, dout_valid, dout_sop, dout_eop,
      input  dout_pop
   );

   modport slave (
      input  mst_address, mst_read, mst_burstcount,
      output mst_waitrequest, mst_readdata, mst_readdatavalid,
      input  dout_data, dout_valid, dout_sop, dout_eop,
      output dout_pop
   );
endinterface

// File: rtl/vfr_frame_fetch_ctrl.sv
// Frame-fetch engine: reads one frame in credit-gated bursts and forwards
// the returned words with sop/eop flags; pulses eof_irq per completed frame.
module vfr_frame_fetch_ctrl #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 64,
   parameter int BURST_WIDTH  = 5,
   parameter int MAX_BURST    = 16,
   parameter int WORDS_WIDTH  = 24,
   parameter int FIFO_DEPTH   = 64,
   parameter int CREDIT_WIDTH = 7
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [ADDR_WIDTH-1:0]  frame_base,
   input  logic [WORDS_WIDTH-1:0] frame_words,
   output logic                   stopped,
   output logic                   eof_irq,
   vfr_frame_fetch_ctrl_if.master bus
);
   localparam int BYTES = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DRAIN} state_t;
   state_t state, state_nx;

   logic [ADDR_WIDTH-1:0]   addr;
   logic [WORDS_WIDTH-1:0]  to_issue, to_recv;
   logic                    first;
   logic [CREDIT_WIDTH-1:0] credits, credits_nx;
   logic [BURST_WIDTH-1:0]  len;
   logic                    accept, can_issue, pop_ok, last_word, ret_en;

   always_comb begin
      len       = (to_issue > WORDS_WIDTH'(MAX_BURST)) ? BURST_WIDTH'(MAX_BURST)
                                                       : to_issue[BURST_WIDTH-1:0];
      accept    = bus.mst_read & ~bus.mst_waitrequest;
      // A new burst goes out when the bus is free or the current one is being accepted.
      can_issue = (state == ISSUE) && (to_issue != '0) && (!bus.mst_read || accept) &&
                  (credits >= CREDIT_WIDTH'(len));
      pop_ok    = bus.dout_pop && (credits != CREDIT_WIDTH'(FIFO_DEPTH));
      credits_nx = credits + CREDIT_WIDTH'(pop_ok) - (can_issue ? CREDIT_WIDTH'(len) : '0);
      ret_en    = bus.mst_readdatavalid && ((state == ISSUE) || (state == DRAIN));
      last_word = ret_en && (to_recv == WORDS_WIDTH'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (enable && (frame_words != '0)) state_nx = LOAD;
         LOAD:    state_nx = ISSUE;
         ISSUE:   if ((to_issue == '0) && (!bus.mst_read || accept)) state_nx = DRAIN;
         DRAIN:   if (to_recv == '0)
                     state_nx = (enable && (frame_words != '0)) ? LOAD : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb stopped = (state == IDLE);

   // addr/to_issue advance when a burst is presented; they only feed later
   // bursts, so this is equivalent to advancing on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr               <= '0;
         to_issue           <= '0;
         to_recv            <= '0;
         first              <= 1'b0;
         credits            <= CREDIT_WIDTH'(FIFO_DEPTH);
         bus.mst_read       <= 1'b0;
         bus.mst_address    <= '0;
         bus.mst_burstcount <= '0;
         bus.dout_data      <= '0;
         bus.dout_valid     <= 1'b0;
         bus.dout_sop       <= 1'b0;
         bus.dout_eop       <= 1'b0;
         eof_irq            <= 1'b0;
      end else begin
         credits <= credits_nx;
         if (state == LOAD) begin
            addr     <= frame_base;
            to_issue <= frame_words;
            to_recv  <= frame_words;
            first    <= 1'b1;
         end
         if (can_issue) begin
            bus.mst_read       <= 1'b1;
            bus.mst_address    <= addr;
            bus.mst_burstcount <= len;
            addr               <= addr + ADDR_WIDTH'(len) * ADDR_WIDTH'(BYTES);
            to_issue           <= to_issue - WORDS_WIDTH'(len);
         end else if (accept) begin
            bus.mst_read <= 1'b0;
         end
         bus.dout_valid <= 1'b0;
         bus.dout_sop   <= 1'b0;
         bus.dout_eop   <= 1'b0;
         eof_irq        <= 1'b0;
         if (ret_en) begin
            bus.dout_valid <= 1'b1;
            bus.dout_data  <= bus.mst_readdata;
            bus.dout_sop   <= first;
            bus.dout_eop   <= last_word;
            eof_irq        <= last_word;
            first          <= 1'b0;
            to_recv        <= to_recv - WORDS_WIDTH'(1);
         end
      end
   end
endmodule

// File: tb/tb_vfr_frame_fetch_ctrl.sv
// Directed bench for vfr_frame_fetch_ctrl: memory responder, output monitor
// with a word scoreboard, and hand-computed burst/credit expectations.
module tb_vfr_frame_fetch_ctrl;
   localparam int AW = 32, DW = 64, BW = 5, WW = 24;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          enable = 1'b0;
   logic [AW-1:0] frame_base = '0;
   logic [WW-1:0] frame_words = '0;
   logic          stopped, eof_irq;

   vfr_frame_fetch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) bus ();

   vfr_frame_fetch_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .MAX_BURST(16),
      .WORDS_WIDTH(WW), .FIFO_DEPTH(64), .CREDIT_WIDTH(7)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .frame_base(frame_base),
      .frame_words(frame_words), .stopped(stopped), .eof_irq(eof_irq), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [BW-1:0] len;
   } burst_t;

   burst_t        blog[$];
   logic [AW-1:0] pend[$];
   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] r_addr;
   int unsigned   seq = 32'h100;
   int            widx = 0, nwords = 1, wtotal = 0, irq_cnt = 0, sop_cnt = 0;
   int            n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bench_clear();
      pend.delete(); exp_q.delete(); blog.delete();
      widx = 0; wtotal = 0; irq_cnt = 0; sop_cnt = 0;
   endtask

   task automatic pulse_enable();
      enable = 1'b1;
      tick(1);
      enable = 1'b0;
   endtask

   task automatic wait_irq(input int n, input int budget);
      int k = 0;
      while (irq_cnt < n && k < budget) begin tick(1); k++; end
      if (irq_cnt < n) chk("timeout_irq", irq_cnt, n);
   endtask

   task automatic chk_burst(input int i, input logic [AW-1:0] a, input int l);
      if (i < blog.size()) begin
         chk("burst_addr", blog[i].addr, a);
         chk("burst_len", blog[i].len, l);
      end else chk("burst_missing", blog.size(), i + 1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_stopped", stopped, 1);
      chk("rst_read", bus.mst_read, 0);
      chk("rst_address", bus.mst_address, 0);
      chk("rst_burstcount", bus.mst_burstcount, 0);
      chk("rst_dout_valid", bus.dout_valid, 0);
      chk("rst_dout_sop", bus.dout_sop, 0);
      chk("rst_dout_eop", bus.dout_eop, 0);
      chk("rst_dout_data", bus.dout_data, 0);
      chk("rst_eof_irq", eof_irq, 0);
   endtask

   // Memory: each accepted burst returns its words one per cycle, starting the cycle after accept.
   initial begin
      bus.mst_readdatavalid = 1'b0;
      bus.mst_readdata = '0;
      forever begin
         @(posedge clk); #1;
         if (pend.size() != 0) begin
            r_addr = pend.pop_front();
            bus.mst_readdata = {seq, r_addr};
            exp_q.push_back(bus.mst_readdata);
            seq++;
            bus.mst_readdatavalid = 1'b1;
         end else bus.mst_readdatavalid = 1'b0;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (bus.mst_read && !bus.mst_waitrequest) begin
            blog.push_back({bus.mst_address, bus.mst_burstcount});
            for (int i = 0; i < int'(bus.mst_burstcount); i++)
               pend.push_back(bus.mst_address + AW'(8 * i));
         end
         if (bus.dout_valid) begin
            if (exp_q.size() == 0) chk("dout_unexpected", exp_q.size(), 1);
            else chk("dout_data", bus.dout_data, exp_q.pop_front());
            chk("dout_sop", bus.dout_sop, widx == 0);
            chk("dout_eop", bus.dout_eop, widx == nwords - 1);
            chk("eof_irq", eof_irq, widx == nwords - 1);
            if (bus.dout_sop) sop_cnt++;
            if (eof_irq) irq_cnt++;
            wtotal++;
            widx = (widx == nwords - 1) ? 0 : widx + 1;
         end else if (eof_irq) begin
            chk("eof_stray", eof_irq, bus.dout_valid);
            irq_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bus.mst_waitrequest = 1'b0;
      bus.dout_pop = 1'b0;
      #2 rst_n = 1'b0;
      #2 chk_reset_outputs();
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // basic 40-word frame, single enable pulse
      bench_clear();
      bus.dout_pop = 1'b1;
      frame_base = 32'h1000; frame_words = 40; nwords = 40;
      chk("t1_stopped_idle", stopped, 1);
      pulse_enable();
      chk("t1_stopped_busy", stopped, 0);
      wait_irq(1, 200);
      tick(3);
      chk("t1_stopped_done", stopped, 1);
      chk("t1_words", wtotal, 40);
      chk("t1_irqs", irq_cnt, 1);
      chk("t1_bursts", blog.size(), 3);
      chk_burst(0, 32'h1000, 16);
      chk_burst(1, 32'h1080, 16);
      chk_burst(2, 32'h1100, 8);

      // stall the second burst; base rewritten mid-frame must not matter
      bench_clear();
      frame_base = 32'h2000;
      pulse_enable();
      k = 0;
      while (!(bus.mst_read && bus.mst_address == 32'h2080) && k < 20) begin tick(1); k++; end
      chk("t2_second_burst", bus.mst_read && (bus.mst_address == 32'h2080), 1);
      bus.mst_waitrequest = 1'b1;
      frame_base = 32'h9000_0000;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("t2_hold_read", bus.mst_read, 1);
         chk("t2_hold_addr", bus.mst_address, 32'h2080);
         chk("t2_hold_bc", bus.mst_burstcount, 16);
      end
      bus.mst_waitrequest = 1'b0;
      wait_irq(1, 200);
      tick(3);
      chk("t2_words", wtotal, 40);
      chk("t2_bursts", blog.size(), 3);
      chk_burst(0, 32'h2000, 16);
      chk_burst(1, 32'h2080, 16);
      chk_burst(2, 32'h2100, 8);

      // credit throttle: no pops, 200-word frame
      bench_clear();
      bus.dout_pop = 1'b0;
      frame_base = 32'h1_0000; frame_words = 200; nwords = 200;
      pulse_enable();
      tick(80);
      chk("t3_bursts", blog.size(), 4);
      chk("t3_read_low", bus.mst_read, 0);
      chk("t3_words", wtotal, 64);
      for (int i = 0; i < 4; i++) chk_burst(i, 32'h1_0000 + 32'(i * 128), 16);
      bus.dout_pop = 1'b1;
      tick(16);
      bus.dout_pop = 1'b0;
      tick(25);
      chk("t3_bursts_after_pop", blog.size(), 5);
      chk_burst(4, 32'h1_0200, 16);
      chk("t3_words_after_pop", wtotal, 80);

      // reset while a burst is held by waitrequest
      bus.mst_waitrequest = 1'b1;
      bus.dout_pop = 1'b1;
      tick(16);
      bus.dout_pop = 1'b0;
      tick(3);
      chk("t6_read_held", bus.mst_read, 1);
      chk("t6_addr_held", bus.mst_address, 32'h1_0280);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs();
      bench_clear();
      bus.mst_waitrequest = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(10);
      chk("t6_idle_stopped", stopped, 1);
      chk("t6_idle_noreads", blog.size(), 0);

      // credits restored to full by reset: exactly 64 words requested again
      frame_base = 32'h2_0000; frame_words = 200; nwords = 200;
      pulse_enable();
      tick(80);
      chk("t6_credit_bursts", blog.size(), 4);
      chk_burst(0, 32'h2_0000, 16);
      rst_n = 1'b0;
      tick(2);
      bench_clear();
      rst_n = 1'b1;
      tick(2);

      // continuous 3-word frames; base changes mid-frame 3
      bus.dout_pop = 1'b1;
      frame_base = 32'h3000; frame_words = 3; nwords = 3;
      enable = 1'b1;
      k = 0;
      while (sop_cnt < 3 && k < 100) begin tick(1); k++; end
      chk("t4_sop3_seen", sop_cnt >= 3, 1);
      frame_base = 32'h4000;
      wait_irq(6, 200);
      enable = 1'b0;
      k = 0;
      while (!stopped && k < 50) begin tick(1); k++; end
      tick(3);
      chk("t4_frames", irq_cnt >= 6, 1);
      chk("t4_sop_vs_irq", sop_cnt, irq_cnt);
      chk("t4_bursts", blog.size(), irq_cnt);
      chk("t4_words", wtotal, 3 * irq_cnt);
      for (int i = 0; i < blog.size(); i++)
         chk_burst(i, (i < 3) ? 32'h3000 : 32'h4000, 3);

      // zero-word frame is ignored
      bench_clear();
      frame_words = 0;
      enable = 1'b1;
      tick(10);
      chk("t5_zero_stopped", stopped, 1);
      chk("t5_zero_reads", blog.size(), 0);
      chk("t5_zero_irq", irq_cnt, 0);
      enable = 1'b0;

      // single-word frame: sop, eop and eof_irq together
      frame_base = 32'h5008; frame_words = 1; nwords = 1;
      pulse_enable();
      wait_irq(1, 50);
      tick(3);
      chk("t5_one_words", wtotal, 1);
      chk("t5_one_bursts", blog.size(), 1);
      chk_burst(0, 32'h5008, 1);
      chk("t5_one_stopped", stopped, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/vfr_frame_fetch_ctrl.md
Name: vfr_frame_fetch_ctrl

Overview:
- Frame-fetch engine directly downstream of the frame reader's Avalon-MM control slave; consumes its enable and register outputs, returns stopped and the end-of-frame interrupt.
- Reads one frame (base address, word count) from memory through a bursting Avalon-MM read master.
- Forwards returned words with start/end-of-frame flags to the pixel FIFO.
- Issues a burst only when FIFO credits cover the whole burst, so the FIFO never overflows.

Parameters:
- ADDR_WIDTH, 32, master byte-address width
- DATA_WIDTH, 64, master/readdata width; bytes per word = DATA_WIDTH/8
- BURST_WIDTH, 5, burstcount width
- MAX_BURST, 16, maximum burst length in words, ≤ 2^(BURST_WIDTH-1)
- WORDS_WIDTH, 24, frame word-count width
- FIFO_DEPTH, 64, downstream FIFO depth in words (initial credit), ≥ MAX_BURST
- CREDIT_WIDTH, 7, credit counter width, holds 0..FIFO_DEPTH

Ports:
- clk, in, 1, sole clock
- rst_n, in, 1, asynchronous active-low reset
- enable, in, 1, go bit from control slave
- frame_base, in, ADDR_WIDTH, frame start byte address (slave register 0)
- frame_words, in, WORDS_WIDTH, words per frame (slave register 1)
- stopped, out, 1, high when idle; to slave stopped input
- eof_irq, out, 1, one-cycle pulse per completed frame; to slave interrupts[0]
- mst_address, out, ADDR_WIDTH, burst start address
- mst_read, out, 1, read request
- mst_burstcount, out, BURST_WIDTH, burst length
- mst_waitrequest, in, 1, slave stall
- mst_readdata, in, DATA_WIDTH, returned word
- mst_readdatavalid, in, 1, returned word valid
- dout_data, out, DATA_WIDTH, word to FIFO
- dout_valid, out, 1, write strobe to FIFO
- dout_sop, out, 1, first word of frame
- dout_eop, out, 1, last word of frame
- dout_pop, in, 1, FIFO read pulse; returns one credit

Behaviour:
- Reset (rst_n low, async):
  - State = IDLE; stopped = 1.
  - mst_read, eof_irq, dout_valid, dout_sop, dout_eop = 0.
  - mst_address, mst_burstcount, dout_data = 0.
  - credits = FIFO_DEPTH.
- Reset mid-frame aborts the frame immediately. The bench never checks in-flight data after a reset.
- IDLE:
  - stopped = 1.
  - enable = 1 and frame_words ≠ 0 → LOAD next cycle.
  - frame_words = 0: stay IDLE; no irq, no reads.
- LOAD (1 cycle):
  - Shadow frame_base into addr and frame_words into to_issue and to_recv.
  - Arm first-word flag; stopped = 0.
  - Register changes after LOAD do not affect the current frame.
- ISSUE:
  - Burst length len = min(MAX_BURST, to_issue).
  - When mst_read = 0 and credits ≥ len: assert mst_read with mst_address = addr, mst_burstcount = len, and subtract len from credits in the same cycle.
  - While mst_read = 1 and mst_waitrequest = 1, hold address, read and burstcount stable.
  - Accept when mst_read = 1 and mst_waitrequest = 0:
    - addr += len × DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
    - to_issue -= len.
    - Deassert mst_read next cycle, or issue the next burst back-to-back if credits allow.
  - to_issue reaches 0 → DRAIN.
- Return path (any non-IDLE state):
  - mst_readdatavalid → dout_valid = 1 next cycle, dout_data = mst_readdata (1-cycle latency).
  - dout_sop = 1 on the first word of the frame.
  - dout_eop = 1 when to_recv = 1.
  - Each returned word decrements to_recv.
  - Single-word frame: sop = eop = 1.
- Credits:
  - +1 per dout_pop cycle, −len per issued burst; both may occur in the same cycle (net update).
  - Never exceeds FIFO_DEPTH. A dout_pop at full credits is ignored.
- DRAIN:
  - When the eop word is output, pulse eof_irq = 1 in that same cycle.
  - Next state: LOAD if enable = 1 (back-to-back frames, no idle gap beyond LOAD), else IDLE.
- enable deasserted mid-frame: the current frame completes normally, then the block goes to IDLE.
- Words per frame is not required to be a multiple of MAX_BURST; the final burst is shorter.
- Reads never straddle frames: the next LOAD happens only after all words of the current frame have returned.

Test Plan:
- Basic frame: frame_base = 0x1000, frame_words = 40, enable pulsed high then low, waitrequest = 0, readdatavalid one cycle after accept, dout_pop every cycle → bursts 16 @0x1000, 16 @0x1080, 8 @0x1100; 40 dout_valid, sop on word 0, eop on word 39; one eof_irq; stopped 1 → 0 → 1.
- Waitrequest stall: hold waitrequest = 1 for 5 cycles on the second burst → address/burstcount stable throughout; no extra burst; 40 words total.
- Credit throttle: FIFO_DEPTH = 64, frame_words = 200, no dout_pop → exactly 64 words requested then mst_read stays low; pop 16 → one more burst of 16 issued.
- Continuous mode: enable held 1, frame_words = 3 → frames repeat; each frame shows sop/eop and one eof_irq. Change frame_base mid-frame → new base used only from the next frame.
- Edge cases: frame_words = 0 with enable = 1 → no reads, stopped stays 1. frame_words = 1 → single word with sop = eop = 1 and eof_irq in the same cycle.
- Reset mid-burst: assert rst_n = 0 during ISSUE → all outputs at reset values asynchronously, credits = FIFO_DEPTH; after release with enable = 0, block stays IDLE.
